// File: rtl/snd_mixer_if.sv
// Control/data bundle between the sound chips' sample bus and the mixer.
// The mixer takes the slave modport; the driving subsystem takes master.
interface snd_mixer_if #(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 16,
    parameter int GAIN_W   = 12,
    parameter int OUT_W    = 16
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                     sample_ce;
    logic [CHANNELS*IN_W-1:0] ch_in;
    logic [CHANNELS-1:0]      mute;
    logic                     gain_wr;
    logic [SEL_W-1:0]         gain_sel;
    logic [GAIN_W-1:0]        gain_din;
    logic                     flag_clr;
    logic [OUT_W-1:0]         sample;
    logic                     sample_valid;
    logic                     busy;
    logic                     clip;
    logic                     overrun;

    modport master (
        output sample_ce, ch_in, mute, gain_wr, gain_sel, gain_din, flag_clr,
        input  sample, sample_valid, busy, clip, overrun
    );

    modport slave (
        input  sample_ce, ch_in, mute, gain_wr, gain_sel, gain_din, flag_clr,
        output sample, sample_valid, busy, clip, overrun
    );
endinterface

// File: rtl/snd_mixer.sv
// Time-multiplexed gain/sum/saturate mixer: one multiply-accumulate per
// channel per frame, double-buffered gains latched on the frame strobe.
module snd_mixer #(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 16,
    parameter int GAIN_W   = 12,
    parameter int FRAC     = 7,
    parameter int OUT_W    = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    snd_mixer_if.slave    bus
);
    localparam int SEL_W  = $clog2(CHANNELS);
    localparam int PROD_W = IN_W + GAIN_W + 1;
    localparam int ACC_W  = IN_W + GAIN_W + 1 + SEL_W;

    localparam logic [GAIN_W-1:0]       UNITY    = GAIN_W'(1 << FRAC);
    localparam logic [SEL_W-1:0]        LAST_IDX = SEL_W'(CHANNELS - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN  = ~OUT_MAX;

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

    state_t state_reg, state_next;

    logic                     start;
    logic                     wr_ok;
    logic [GAIN_W-1:0]        act_w  [CHANNELS];
    logic signed [IN_W-1:0]   in_w   [CHANNELS];
    logic [CHANNELS-1:0]      mute_w;

    logic signed [ACC_W-1:0]  acc_reg;
    logic [SEL_W-1:0]         idx_reg;
    logic [OUT_W-1:0]         sample_reg;
    logic                     valid_reg;
    logic                     clip_reg;
    logic                     overrun_reg;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  r;
    logic                     sat_hi;
    logic                     sat_lo;
    logic                     clip_set;
    logic                     overrun_set;

    assign start       = (state_reg == ST_IDLE) && bus.sample_ce;
    assign wr_ok       = bus.gain_wr && (int'(bus.gain_sel) < CHANNELS);
    assign overrun_set = bus.sample_ce && (state_reg != ST_IDLE);

    // Per-channel gain double buffer and frame snapshot. A write landing on
    // the frame strobe is forwarded straight into the active copy.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_ch
            logic [GAIN_W-1:0]      pend_reg;
            logic [GAIN_W-1:0]      act_reg;
            logic signed [IN_W-1:0] in_s_reg;
            logic                   mute_s_reg;
            logic                   hit;

            assign hit = wr_ok && (bus.gain_sel == SEL_W'(gi));

            always_ff @(posedge clk_sys) begin
                if (!reset_n) begin
                    pend_reg   <= UNITY;
                    act_reg    <= UNITY;
                    in_s_reg   <= '0;
                    mute_s_reg <= 1'b0;
                end else begin
                    if (hit) begin
                        pend_reg <= bus.gain_din;
                    end
                    if (start) begin
                        act_reg    <= hit ? bus.gain_din : pend_reg;
                        in_s_reg   <= bus.ch_in[gi*IN_W +: IN_W];
                        mute_s_reg <= bus.mute[gi];
                    end
                end
            end

            assign act_w[gi]  = act_reg;
            assign in_w[gi]   = in_s_reg;
            assign mute_w[gi] = mute_s_reg;
        end
    endgenerate

    // Single shared multiplier; gain is zero-extended so it stays non-negative.
    always_comb begin
        prod = in_w[idx_reg] * $signed({1'b0, act_w[idx_reg]});
        term = mute_w[idx_reg] ? '0
                               : $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
    end

    always_comb begin
        r        = acc_reg >>> FRAC;
        sat_hi   = r > OUT_MAX;
        sat_lo   = r < OUT_MIN;
        clip_set = (state_reg == ST_OUT) && (sat_hi || sat_lo);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.sample_ce) state_next = ST_MAC;
            ST_MAC:  if (idx_reg == LAST_IDX) state_next = ST_OUT;
            ST_OUT:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            acc_reg     <= '0;
            idx_reg     <= '0;
            sample_reg  <= '0;
            valid_reg   <= 1'b0;
            clip_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.sample_ce) begin
                        acc_reg <= '0;
                        idx_reg <= '0;
                    end
                end
                ST_MAC: begin
                    acc_reg <= acc_reg + term;
                    idx_reg <= idx_reg + 1'b1;
                end
                ST_OUT: begin
                    if (sat_hi) begin
                        sample_reg <= OUT_MAX[OUT_W-1:0];
                    end else if (sat_lo) begin
                        sample_reg <= OUT_MIN[OUT_W-1:0];
                    end else begin
                        sample_reg <= r[OUT_W-1:0];
                    end
                    valid_reg <= 1'b1;
                end
                default: ;
            endcase

            // A set event in the same cycle as a clear takes precedence.
            if (clip_set) begin
                clip_reg <= 1'b1;
            end else if (bus.flag_clr) begin
                clip_reg <= 1'b0;
            end
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end else if (bus.flag_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign bus.sample       = sample_reg;
    assign bus.sample_valid = valid_reg;
    assign bus.busy         = (state_reg != ST_IDLE);
    assign bus.clip         = clip_reg;
    assign bus.overrun      = overrun_reg;
endmodule

// File: doc/snd_mixer.md
# snd_mixer

Parametrised, time-multiplexed sound mixer that combines `CHANNELS` signed PCM/FM sources into one saturated output sample. Each source has a programmable unsigned fixed-point gain and a mute bit. Gain writes are double-buffered so they apply on a frame boundary. It replaces the fixed two-source gain/sum/clip stage inside the sound subsystem and sits between the sound chips (jt51, ga20, filters) and the core's audio output.

## Interface
- `CHANNELS`, 4: number of input sources, 2..16.
- `IN_W`, 16: input sample width, signed.
- `GAIN_W`, 12: gain width, unsigned.
- `FRAC`, 7: fractional bits of gain; gain `1<<FRAC` = 1.0.
- `OUT_W`, 16: output sample width, signed.
- Derived: `SEL_W = $clog2(CHANNELS)`; `ACC_W = IN_W + GAIN_W + 1 + SEL_W`.

Ports:
- `clk_sys` in 1: system clock (40 MHz). One clock domain only.
- `reset_n` in 1: synchronous, active-low reset.
- `sample_ce` in 1: frame start strobe, one cycle wide.
- `ch_in` in `CHANNELS*IN_W`: packed signed inputs; channel i is at `[i*IN_W +: IN_W]`.
- `mute` in `CHANNELS`: per-channel mute, sampled at frame start.
- `gain_wr` in 1: gain write strobe.
- `gain_sel` in `SEL_W`: channel to write.
- `gain_din` in `GAIN_W`: gain value.
- `sample` out `OUT_W`: mixed, saturated sample (registered).
- `sample_valid` out 1: one-cycle pulse when `sample` updates.
- `busy` out 1: high while a frame is in progress.
- `clip` out 1: sticky, set when saturation occurs.
- `overrun` out 1: sticky, set when `sample_ce` arrives while busy.
- `flag_clr` in 1: clears `clip` and `overrun`.

## Operation
- Gain registers:
  - `pend[i]` is written by `gain_wr` at `gain_sel`. A `gain_sel >= CHANNELS` write is ignored.
  - `act[i]` is the copy used for accumulation. It is copied from `pend` at frame start.
  - Reset value of both `pend` and `act` is `1<<FRAC`.
- States are IDLE, MAC and OUT.
- IDLE:
  - On `sample_ce`: snapshot `ch_in`, `mute` and `pend` into working registers.
  - If `gain_wr` coincides with `sample_ce`, the new value is forwarded into that frame's snapshot.
  - Set `acc <= 0`, `idx <= 0`, go to MAC.
- MAC:
  - Each cycle: `acc <= acc + (mute_s[idx] ? 0 : $signed(in_s[idx]) * $signed({1'b0, act[idx]}))`, then `idx++`.
  - When `idx == CHANNELS-1`, that cycle's add completes and the state goes to OUT.
  - Use a single multiplier.
- OUT:
  - Compute `r = acc >>> FRAC` (arithmetic shift, floor toward −inf).
  - If `r > 2^(OUT_W-1)-1`: `sample <= 2^(OUT_W-1)-1`.
  - Else if `r < -2^(OUT_W-1)`: `sample <= -2^(OUT_W-1)`.
  - Else `sample <= r[OUT_W-1:0]`.
  - Set `clip` on either saturation case.
  - Pulse `sample_valid`, return to IDLE.
- `ACC_W` guarantees the accumulator never overflows internally.
- `sample_ce` in MAC or OUT:
  - The strobe is ignored and `overrun <= 1`.
  - The frame in progress is unaffected.
- Flag priority: if `flag_clr` and a set event occur in the same cycle, the set wins.
- `sample` holds its value between frames.
- Reset values: `sample = 0`, `sample_valid = 0`, `busy = 0`, `clip = 0`, `overrun = 0`, state IDLE, `acc = 0`.
- Reset asserted mid-frame aborts the frame. No `sample_valid` is emitted for it, and `sample` is forced to 0.

## Timing
- Edge E0 samples `sample_ce` high. Edges E1..E(CHANNELS) accumulate channels 0..CHANNELS-1. Edge E(CHANNELS+1) registers `sample`.
- `sample_valid` is high for exactly the one cycle following E(CHANNELS+1).
- Latency from `sample_ce` to `sample` is `CHANNELS+1` clocks.
- `busy` is high from after E0 until after E(CHANNELS+1).
- A new frame may start on the cycle `sample_valid` is high; the minimum frame period is `CHANNELS+2` clocks.
- Gain write timing:
  - A `gain_wr` at any cycle after E0 of frame N takes effect in frame N+1.
  - A `gain_wr` at E0 takes effect in frame N.
- `ch_in` changes after E0 do not affect the current frame.

## Test plan
Unless stated otherwise, `CHANNELS=4`, `FRAC=7` and all gains are 128.
- Unity mix: `ch_in` = {1000, 2000, −500, 0}, `sample_ce` → after 5 clocks, `sample = 2500`, `sample_valid` pulses once, `clip = 0`.
- Positive saturation: all inputs 30000 → `sample = 16'h7fff`, `clip = 1`. Then `flag_clr` → `clip = 0`.
- Negative saturation and floor:
  - All inputs −30000 → `sample = 16'h8000`.
  - ch0 = −1 with gain 64, others 0 → `sample = −1` (floor, not 0).
- Gain and mute:
  - Write gain 0x1C0 (3.5) to ch0 with ch0 = 1000 → `sample = 3500`.
  - `mute[0] = 1` → `sample = 0`.
  - A gain write issued mid-frame leaves that frame at the old gain and applies on the next frame.
  - A write coinciding with `sample_ce` applies to that same frame.
- Overrun: `sample_ce` again 2 clocks after the first → `overrun = 1`, exactly one `sample_valid`, result equals the single-frame value.
- Reset mid-frame: drive `reset_n = 0` at E2 for 1 clock → no `sample_valid`, `sample = 0`, all gains back to 128, next frame correct.
